// File: rtl/axi_lite_write_regs.sv
// AXI4-Lite write-only slave: terminates AW/W/B into a bank of control
// registers, with byte strobes, SLVERR on out-of-range words, per-register
// write pulses and a debug view of the handshake FSM.
module axi_lite_write_regs #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [1:0]                     fsm_state
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFFS_W = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE         = 2'h0,
        DONE         = 2'h1,
        WAITING_DATA = 2'h2,
        WAITING_ADDR = 2'h3
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

    logic                    commit_c;
    logic [IDX_W-1:0]        commit_idx_c;
    logic [DATA_WIDTH-1:0]   commit_data_c;
    logic [STRB_W-1:0]       commit_strb_c;
    logic [NUM_REGS-1:0]     hit_c;
    logic [IDX_W-1:0]        aw_idx_c;
    logic                    unused_addr_lsb;

    // Word index of the incoming address; byte-offset bits are don't-care
    assign aw_idx_c        = s_awaddr[ADDR_WIDTH-1:OFFS_W];
    assign unused_addr_lsb = ^s_awaddr[OFFS_W-1:0];

    // Next-state, capture and commit decode
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        data_d        = data_q;
        strb_d        = strb_q;
        commit_c      = 1'b0;
        commit_idx_c  = idx_q;
        commit_data_c = data_q;
        commit_strb_c = strb_q;
        case (state_q)
            IDLE: begin
                if (s_awvalid && s_wvalid) begin
                    idx_d         = aw_idx_c;
                    data_d        = s_wdata;
                    strb_d        = s_wstrb;
                    commit_c      = 1'b1;
                    commit_idx_c  = aw_idx_c;
                    commit_data_c = s_wdata;
                    commit_strb_c = s_wstrb;
                    state_d       = DONE;
                end else if (s_awvalid) begin
                    idx_d   = aw_idx_c;
                    state_d = WAITING_DATA;
                end else if (s_wvalid) begin
                    data_d  = s_wdata;
                    strb_d  = s_wstrb;
                    state_d = WAITING_ADDR;
                end
            end
            WAITING_DATA: begin
                if (s_wvalid) begin
                    data_d        = s_wdata;
                    strb_d        = s_wstrb;
                    commit_c      = 1'b1;
                    commit_data_c = s_wdata;
                    commit_strb_c = s_wstrb;
                    state_d       = DONE;
                end
            end
            WAITING_ADDR: begin
                if (s_awvalid) begin
                    idx_d        = aw_idx_c;
                    commit_c     = 1'b1;
                    commit_idx_c = aw_idx_c;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (s_bready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register select and response for the commit cycle
    always_comb begin
        hit_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            hit_c[i] = commit_c && (commit_idx_c == IDX_W'(i));
        end
        wr_pulse_d = hit_c;
        bresp_d    = bresp_q;
        if (commit_c) begin
            bresp_d = (|hit_c) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // FSM state, captured transaction and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Register bank with byte-strobe merge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (hit_c[i]) begin
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (commit_strb_c[b]) begin
                            regs_q[i][b*8 +: 8] <= commit_data_c[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Flatten the register bank onto the export bus
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    assign s_awready = (state_q == IDLE) || (state_q == WAITING_ADDR);
    assign s_wready  = (state_q == IDLE) || (state_q == WAITING_DATA);
    assign s_bvalid  = (state_q == DONE);
    assign s_bresp   = bresp_q;
    assign wr_pulse  = wr_pulse_q;
    assign fsm_state = state_q;

endmodule
